synaptic_current_accumulator: RTL
=================================

Name: synaptic_current_accumulator

Overview:
- Upstream stage of izhikevich_neuron: converts address-event (AER) spike arrivals into the Q16.16 input current consumed on the neuron's I_in every clock.
- Buffers incoming synapse-index events in a small FIFO and looks up a programmable per-synapse weight.
- Integrates each weight into an exponentially decaying, saturating current register.

Parameters:
- N_SYN, 16, number of synapses; weight table depth.
- FIFO_DEPTH, 8, event FIFO entries (power of two, >= 2).
- TAU_SHIFT, 3, decay per cycle is acc >>> TAU_SHIFT.
- I_BIAS, 0, signed Q16.16 constant added every cycle.
- I_MAX, 100<<<16, signed Q16.16 upper saturation limit.
- I_MIN, -(100<<<16), signed Q16.16 lower saturation limit.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- ev_valid  in  1  event offered.
- ev_ready  out  1  FIFO can accept.
- ev_addr  in  $clog2(N_SYN)  synapse index of offered event.
- w_we  in  1  weight write strobe.
- w_addr  in  $clog2(N_SYN)  weight write index.
- w_data  in  32  signed Q16.16 weight.
- I_out  out  32  signed Q16.16 current; connects to neuron I_in.
- sat_pulse  out  1  high for one cycle when the accumulator update clamped.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on any edge with reset=1:
  - FIFO emptied; fifo_level=0.
  - Lookup stage valid cleared.
  - All weights=0; accumulator=0, so I_out=0.
  - sat_pulse=0.
- ev_ready is combinational: !reset && fifo_level<FIFO_DEPTH. There is no same-cycle push-when-full even if a pop occurs.
- Push: ev_valid && ev_ready at an edge writes ev_addr at the FIFO tail. ev_addr is ignored when ev_valid=0.
- Pop/lookup (stage 1):
  - At an edge with FIFO non-empty and w_we=0: head popped, w_q <= weight[head], w_q_vld <= 1.
  - Otherwise w_q_vld <= 0.
  - w_we=1 stalls the pop; the weight table is single-ported.
  - Simultaneous push and pop leaves the level unchanged.
- Weight write: at an edge with w_we=1, weight[w_addr] <= w_data. Because a write and a lookup never share a cycle, there is no read/write hazard.
- Accumulate (stage 2), every non-reset edge:
  - sum = acc - (acc >>> TAU_SHIFT) + I_BIAS + (w_q_vld ? w_q : 0), computed in 34-bit signed.
  - acc <= clamp(sum, I_MIN, I_MAX).
  - sat_pulse <= (sum>I_MAX || sum<I_MIN).
- I_out = acc; it is a registered output with no combinational path from inputs.
- Latency: an event accepted at edge t with an empty FIFO and w_we low at t+1 is popped at edge t+1. Its weight enters acc at edge t+2 and is visible on I_out after t+2.
- Events are processed strictly in arrival order. One pop per cycle maximum.
- Decay uses an arithmetic shift:
  - Negative acc converges to 0 (-1 >>> k = -1, so -1 -> 0).
  - A positive residual below 2^TAU_SHIFT LSB persists. This is accepted.
- Mid-operation reset discards queued and in-flight events; none reach acc after reset deasserts.

Decomposition:
- Package ratbrain_pkg:
  - typedef fixed_t (logic signed [31:0]); FRAC_BITS=16.
  - Saturation helper function.
  - Shared neuron constants (threshold, C, D defaults), so that neuron and accumulator agree on format.
- Sub-module aer_event_fifo: parameterised depth/width, synchronous reset, push/pop/level. It is reused later for spike output buffering.
- Weight table, decay, and clamp stay in the top module.

Test Plan:
- Reset: hold reset 2 cycles with ev_valid=1 -> ev_ready=0, I_out=0, fifo_level=0, sat_pulse=0. After release, ev_ready=1.
- Single event: write weight[3]=655360 (10.0); push addr 3 at edge t -> I_out=655360 after t+2, 573440 after t+3, 501760 after t+4.
- Backpressure: hold w_we=1 while pushing 10 consecutive events -> fifo_level reaches 8, ev_ready=0, events 9-10 held off. Drop w_we -> level decrements by 1 per cycle and all 10 are consumed in order (distinct weights identify order).
- Saturation: weight[0]=127<<<16; push addr 0 on two consecutive cycles -> first update sum 8323072 > I_MAX, acc=6553600, sat_pulse=1. Pulse clears on a non-clamping cycle.
- Negative decay: weight[5]=-(4<<<16); one event -> I_out=-262144, then decays monotonically to exactly 0, never positive.
- Mid-operation reset: 5 events queued, assert reset 1 cycle -> next cycle fifo_level=0 and I_out=0. Old weights read 0 afterwards, so queued events contribute nothing.

Source files
------------

// File: rtl/ratbrain_pkg.sv
// ratbrain_pkg: shared Q16.16 fixed-point format, neuron constants and saturation helper
package ratbrain_pkg;
  typedef logic signed [31:0] fixed_t;
  localparam int FRAC_BITS = 16;
  localparam fixed_t V_THRESH = 30 <<< FRAC_BITS;
  localparam fixed_t C_DEFAULT = -(65 <<< FRAC_BITS);
  localparam fixed_t D_DEFAULT = 8 <<< FRAC_BITS;
  function automatic fixed_t sat_fixed(input logic signed [33:0] x, input fixed_t lo, input fixed_t hi);
    return x > 34'(hi) ? hi : x < 34'(lo) ? lo : fixed_t'(x[31:0]);
  endfunction
endpackage

// File: rtl/aer_event_fifo.sv
// aer_event_fifo: synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored
module aer_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  // storage is not reset; only pointers and count define validity
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/synaptic_current_accumulator.sv
// synaptic_current_accumulator: AER events -> weight lookup -> decaying saturating Q16.16 current
module synaptic_current_accumulator
  import ratbrain_pkg::*;
#(
  parameter int     N_SYN      = 16,
  parameter int     FIFO_DEPTH = 8,
  parameter int     TAU_SHIFT  = 3,
  parameter fixed_t I_BIAS     = 0,
  parameter fixed_t I_MAX      = 100 <<< 16,
  parameter fixed_t I_MIN      = -(100 <<< 16)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic [$clog2(N_SYN)-1:0]      ev_addr,
  input  logic                          w_we,
  input  logic [$clog2(N_SYN)-1:0]      w_addr,
  input  fixed_t                        w_data,
  output fixed_t                        I_out,
  output logic                          sat_pulse,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(N_SYN);
  fixed_t w_tab [N_SYN];
  fixed_t w_q, acc;
  logic w_q_vld, full, empty, pop;
  logic [AW-1:0] head;
  logic signed [33:0] sum;
  assign ev_ready = !reset && !full;
  assign pop = !empty && !w_we;
  assign I_out = acc;
  assign sum = 34'(acc) - 34'(acc >>> TAU_SHIFT) + 34'(I_BIAS) + (w_q_vld ? 34'(w_q) : 34'sd0);
  aer_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(AW)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(ev_valid && ev_ready),
    .pop(pop),
    .din(ev_addr),
    .dout(head),
    .level(fifo_level),
    .full(full),
    .empty(empty)
  );
  // single-ported weight table; writes stall lookups so they never collide
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < N_SYN; i++) w_tab[i] <= '0;
    else if (w_we) w_tab[w_addr] <= w_data;
  // stage 1: pop the head event and fetch its weight
  always_ff @(posedge clk)
    if (reset) begin
      w_q <= '0;
      w_q_vld <= 1'b0;
    end else begin
      w_q_vld <= pop;
      if (pop) w_q <= w_tab[head];
    end
  // stage 2: leaky integrate with clamp and one-cycle saturation flag
  always_ff @(posedge clk)
    if (reset) begin
      acc <= '0;
      sat_pulse <= 1'b0;
    end else begin
      acc <= sat_fixed(sum, I_MIN, I_MAX);
      sat_pulse <= sum > 34'(I_MAX) || sum < 34'(I_MIN);
    end
endmodule
